mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
MEM-stage load/store unit; the responder on the pipeline side that produces the aligned load data the MEM/WB register captures as dmem read data. It accepts one load/store per instruction from the EX/MEM register and drives a word-wide valid/ack data bus. Misaligned accesses are split into two word beats. It stalls the pipeline until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, ack-wait cycles before abort; used only when LSU_TIMEOUT_EN is defined.

Ports:
i_clk  in  1  clock
i_resetn  in  1  reset
i_req  in  1  MEM stage holds a valid load/store
i_we  in  1  1=store, 0=load
i_funct3  in  3  size/sign (RV32I encodings)
i_addr  in  32  byte address
i_wdata  in  32  store data, LSB-justified
o_stall  out  1  freeze IF..MEM
o_done  out  1  one-cycle completion pulse
o_err  out  1  illegal access or timeout, qualified by o_done
o_rd_dmem  out  32  extended load result to mem_wb_reg
o_bus_req  out  1  bus request
o_bus_we  out  1  bus write
o_bus_addr  out  32  word address, [1:0]=0
o_bus_be  out  4  byte enables
o_bus_wdata  out  32  lane-aligned write data
i_bus_ack  in  1  beat accepted; read data valid
i_bus_rdata  in  32  read data

Behaviour:
- Reset: asynchronous, active-low, on i_resetn; clock i_clk. All registered outputs are 0 and state is IDLE. o_stall is forced 0 while i_resetn is low. Reset mid-transfer drops o_bus_req immediately.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE, i_req=1: latch request and go to BEAT0.
  - o_bus_req=1.
  - addr = {i_addr[31:2],00}.
  - be = (mask<<off)[3:0], where mask is 0001 (byte), 0011 (half) or 1111 (word) and off = i_addr[1:0].
  - wdata = i_wdata<<8*off.
- IDLE with illegal funct3: go straight to DONE with o_err=1 and no bus cycle. Illegal means loads 011/110/111, stores other than 000/001/010.
- BEATn: all bus outputs stay stable until i_bus_ack. Ack may arrive in the first request cycle or later.
- BEAT0 ack: capture rdata0.
  - Split access (half with off=3, or word with off≠0): go to BEAT1.
    - addr+4, wrapping 0xFFFFFFFC to 0x00000000.
    - be = mask>>(4-off).
    - wdata = i_wdata>>8*(4-off).
  - Otherwise: go to DONE and drop o_bus_req.
- BEAT1 ack: capture rdata1, go to DONE, drop o_bus_req.
- DONE: o_done=1 for one cycle, then IDLE.
  - Load: o_rd_dmem = ({rdata1,rdata0}>>8*off), truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - Store or error: o_rd_dmem holds its previous value; on error it is 0.
- o_stall = i_req & ~o_done, combinational.
- Minimum latency with zero-wait ack:
  - Aligned access: 3 cycles, i_req seen → o_done.
  - Split access: 4 cycles.
- i_req dropping mid-transfer (flush) does not abort; the access completes with o_done.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: an 8-bit wait counter resets at each beat start and counts cycles without ack. When it reaches TIMEOUT_CYCLES: drop o_bus_req, go to DONE, o_err=1, o_rd_dmem=0. Any partial store beats already written are not rolled back.
- Undefined: no counter; the unit waits for ack indefinitely.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State encoding.
  - size-mask and split-detect functions.
- Sub-module lsu_align: combinational lane shifting, byte-enable generation, and load extraction/extension. The FSM and registers stay in mem_stage_lsu.

Test Plan:
- LW 0x100, ack same cycle, rdata 0xDEADBEEF → one beat (addr 0x100, be 1111); o_done on cycle 3; o_rd_dmem 0xDEADBEEF.
- LB 0x103, rdata 0x80123456 → be 1000, o_rd_dmem 0xFFFFFF80. LBU at the same address → 0x00000080.
- SW 0x102, wdata 0xAABBCCDD:
  - Beat0: addr 0x100, be 1100, wdata 0xCCDD0000.
  - Beat1: addr 0x104, be 0011, wdata 0x0000AABB.
  - o_done on cycle 4.
- LH 0x103:
  - Beat0: rdata 0x34000000, be 1000.
  - Beat1: addr 0x104, rdata 0x00000012, be 0001.
  - Result: o_rd_dmem 0x00001234.
- LW 0x200, ack after 5 cycles → o_stall high and bus outputs stable throughout. A repeat run with i_resetn pulsed low in BEAT0 → all outputs 0 immediately, state IDLE.
- Load with funct3 011 → no o_bus_req; o_done and o_err pulse together. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, an LW with no ack → o_err on completion after 8 wait cycles, o_rd_dmem 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// Holds the RV32I funct3 codes, the FSM state type and the size/split/legality helpers.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return (off == 2'd3);
            2'b10:   return (off != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3[2] | (funct3[1:0] == 2'b11);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables and write data for both beats,
// plus extraction and sign/zero extension of the load result from the two read words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [31:0] rdata_shift;

    // Upper halves of the widened shifts are exactly the second-beat lanes.
    assign be_wide    = {4'b0000, size_mask(funct3)} << off;
    assign be_lo      = be_wide[3:0];
    assign be_hi      = be_wide[7:4];
    assign wdata_wide = {32'h0, wdata} << {off, 3'b000};
    assign wdata_lo   = wdata_wide[31:0];
    assign wdata_hi   = wdata_wide[63:32];

    assign rdata_shift = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});

    always_comb begin
        load_data = rdata_shift;
        case (funct3)
            LB:      load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            LH:      load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            LBU:     load_data = {24'h0, rdata_shift[7:0]};
            LHU:     load_data = {16'h0, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one access per instruction, split into two word beats when misaligned.
// Build option LSU_TIMEOUT_EN adds an ack-wait abort after TIMEOUT_CYCLES cycles.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rd_dmem,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    lsu_state_t  state, state_nxt;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata0_q;

    logic [2:0]  funct3_sel;
    logic [1:0]  off_sel;
    logic [31:0] wdata_sel;
    logic [31:0] rdata_lo, rdata_hi;
    logic [3:0]  be_lo, be_hi;
    logic [31:0] wdata_lo, wdata_hi, load_data;
    logic        req_illegal, split, timeout;

    assign req_illegal = is_illegal(i_we, i_funct3);
    assign split       = is_split(funct3_q, off_q);

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    assign timeout = ~i_bus_ack & (wait_cnt == 8'd0);

    // Reloaded at the start of each beat; terminal count means TIMEOUT_CYCLES ack-less cycles.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            wait_cnt <= 8'd0;
        else if ((state == ST_IDLE) || ((state == ST_BEAT0) && i_bus_ack))
            wait_cnt <= WAIT_LOAD;
        else if (wait_cnt != 8'd0)
            wait_cnt <= wait_cnt - 8'd1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Fresh request drives the aligner in IDLE; latched request drives it afterwards.
    assign funct3_sel = (state == ST_IDLE) ? i_funct3    : funct3_q;
    assign off_sel    = (state == ST_IDLE) ? i_addr[1:0] : off_q;
    assign wdata_sel  = (state == ST_IDLE) ? i_wdata     : wdata_q;
    assign rdata_lo   = (state == ST_BEAT1) ? rdata0_q    : i_bus_rdata;
    assign rdata_hi   = (state == ST_BEAT1) ? i_bus_rdata : 32'h0;

    lsu_align u_align (
        .funct3    (funct3_sel),
        .off       (off_sel),
        .wdata     (wdata_sel),
        .rdata_lo  (rdata_lo),
        .rdata_hi  (rdata_hi),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wdata_lo  (wdata_lo),
        .wdata_hi  (wdata_hi),
        .load_data (load_data)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (i_req)
                    state_nxt = req_illegal ? ST_DONE : ST_BEAT0;
            ST_BEAT0:
                if (i_bus_ack)
                    state_nxt = split ? ST_BEAT1 : ST_DONE;
                else if (timeout)
                    state_nxt = ST_DONE;
            ST_BEAT1:
                if (i_bus_ack || timeout)
                    state_nxt = ST_DONE;
            ST_DONE:
                state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_done  = (state == ST_DONE);
        o_stall = i_resetn & i_req & (state != ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            rdata0_q    <= 32'h0;
            o_err       <= 1'b0;
            o_rd_dmem   <= 32'h0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 32'h0;
            o_bus_be    <= 4'b0000;
            o_bus_wdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        we_q     <= i_we;
                        funct3_q <= i_funct3;
                        off_q    <= i_addr[1:0];
                        wdata_q  <= i_wdata;
                        if (req_illegal) begin
                            o_err     <= 1'b1;
                            o_rd_dmem <= 32'h0;
                        end else begin
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= i_we;
                            o_bus_addr  <= {i_addr[31:2], 2'b00};
                            o_bus_be    <= be_lo;
                            o_bus_wdata <= wdata_lo;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (i_bus_ack) begin
                        rdata0_q <= i_bus_rdata;
                        if (split) begin
                            o_bus_addr  <= o_bus_addr + 32'd4;
                            o_bus_be    <= be_hi;
                            o_bus_wdata <= wdata_hi;
                        end else begin
                            o_bus_req <= 1'b0;
                            if (!we_q)
                                o_rd_dmem <= load_data;
                        end
                    end else if (timeout) begin
                        o_bus_req <= 1'b0;
                        o_err     <= 1'b1;
                        o_rd_dmem <= 32'h0;
                    end
                end
                ST_BEAT1: begin
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        if (!we_q)
                            o_rd_dmem <= load_data;
                    end else if (timeout) begin
                        o_bus_req <= 1'b0;
                        o_err     <= 1'b1;
                        o_rd_dmem <= 32'h0;
                    end
                end
                ST_DONE: o_err <= 1'b0;
                default: o_err <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses push expected beats/completions,
// a negedge monitor pops and compares whenever the DUT acks a beat or pulses o_done.
module tb_mem_stage_lsu;

    logic        i_clk = 1'b0;
    logic        i_resetn;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall, o_done, o_err;
    logic [31:0] o_rd_dmem;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 0;
    logic [31:0] rsp_rd0 = 32'h0;
    logic [31:0] rsp_rd1 = 32'h0;

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rd_dmem   (o_rd_dmem),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: acks each beat after ack_delay wait cycles, junk data otherwise.
    initial begin
        int wcnt;
        int beat;
        wcnt = 0;
        beat = 0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = JUNK;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_bus_req) begin
                if (wcnt >= ack_delay) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = (beat == 0) ? rsp_rd0 : rsp_rd1;
                    beat++;
                    wcnt = 0;
                end else begin
                    i_bus_ack   = 1'b0;
                    i_bus_rdata = JUNK;
                    wcnt++;
                end
            end else begin
                i_bus_ack   = 1'b0;
                i_bus_rdata = JUNK;
                wcnt = 0;
                beat = 0;
            end
        end
    end

    // Monitor: pops expectations on accepted beats and completion pulses.
    initial begin
        beat_t       b;
        done_t       d;
        logic        prev_req, prev_ack, prev_we;
        logic [31:0] prev_addr, prev_wdata;
        logic [3:0]  prev_be;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_we = 1'b0;
        prev_addr = 32'h0;
        prev_wdata = 32'h0;
        prev_be = 4'h0;
        forever begin
            @(negedge i_clk);
            if (i_resetn) begin
                if (o_bus_req && prev_req && !prev_ack) begin
                    chk("stable_addr", o_bus_addr, prev_addr);
                    chk("stable_be", 32'(o_bus_be), 32'(prev_be));
                    chk("stable_wdata", o_bus_wdata, prev_wdata);
                    chk("stable_we", 32'(o_bus_we), 32'(prev_we));
                end
                if (o_bus_req && i_bus_ack) begin
                    if (beat_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got addr %h be %b, expected no beat", o_bus_addr, o_bus_be);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_addr", o_bus_addr, b.addr);
                        chk("beat_be", 32'(o_bus_be), 32'(b.be));
                        chk("beat_we", 32'(o_bus_we), 32'(b.we));
                        chk("beat_wdata", o_bus_wdata, b.wdata);
                    end
                end
                if (o_done) begin
                    if (done_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got o_done 1, expected no completion");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_err", 32'(o_err), 32'(d.err));
                        chk("done_rd_dmem", o_rd_dmem, d.rd);
                    end
                end
            end
            prev_req   = o_bus_req & i_resetn;
            prev_ack   = i_bus_ack;
            prev_we    = o_bus_we;
            prev_addr  = o_bus_addr;
            prev_be    = o_bus_be;
            prev_wdata = o_bus_wdata;
        end
    end

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay,
                       input logic [31:0] rd0, input logic [31:0] rd1, input int nbeats,
                       input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                       input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                       input bit exp_bus, input logic err, input logic [31:0] rd,
                       input int lat, input bit flush);
        int cyc;
        bit seen, got_req, stall_ok;
        beat_t bt;
        done_t dn;
        @(posedge i_clk);
        #1;
        ack_delay = delay;
        rsp_rd0   = rd0;
        rsp_rd1   = rd1;
        if (nbeats > 0) begin
            bt.addr = a0; bt.be = b0; bt.we = we; bt.wdata = w0;
            beat_q.push_back(bt);
        end
        if (nbeats > 1) begin
            bt.addr = a1; bt.be = b1; bt.we = we; bt.wdata = w1;
            beat_q.push_back(bt);
        end
        dn.err = err;
        dn.rd  = rd;
        done_q.push_back(dn);
        i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_req = 1'b1;
        cyc = 1; seen = 0; got_req = 0; stall_ok = 1;
        while (!seen && cyc <= 200) begin
            @(negedge i_clk);
            if (o_bus_req) got_req = 1;
            if (o_done) begin
                seen = 1;
            end else begin
                if (o_stall !== i_req) stall_ok = 0;
                cyc++;
                if (flush && cyc == 3) i_req = 1'b0;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", cyc, lat);
        chk("stall_while_busy", 32'(stall_ok), 32'd1);
        chk("stall_in_done", 32'(o_stall), 32'd0);
        chk("bus_activity", 32'(got_req), 32'(exp_bus));
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_resetn = 1'b0;
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0; i_wdata = 32'h0;
        repeat (2) @(negedge i_clk);
        chk("rst_stall_forced", 32'(o_stall), 32'd0);
        chk("rst_bus_req", 32'(o_bus_req), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_rd_dmem", o_rd_dmem, 32'h0);
        chk("rst_bus_addr", o_bus_addr, 32'h0);
        i_req = 1'b0;
        i_resetn = 1'b1;

        //  we  f3      addr          wdata         dly rd0           rd1           nb a0            b0       w0            a1            b1       w1            bus err rd            lat flush
        run(0, 3'b010, 32'h00000100, 32'h00000000, 0, 32'hDEADBEEF, JUNK,         1, 32'h00000100, 4'b1111, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'hDEADBEEF, 3, 0);
        run(1, 3'b011, 32'h00000100, 32'h12345678, 0, JUNK,         JUNK,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 32'h00000000, 2, 0);
        run(0, 3'b000, 32'h00000103, 32'h00000000, 0, 32'h80123456, JUNK,         1, 32'h00000100, 4'b1000, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'hFFFFFF80, 3, 0);
        run(0, 3'b100, 32'h00000103, 32'h00000000, 0, 32'h80123456, JUNK,         1, 32'h00000100, 4'b1000, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'h00000080, 3, 0);
        run(1, 3'b010, 32'h00000102, 32'hAABBCCDD, 0, JUNK,         JUNK,         2, 32'h00000100, 4'b1100, 32'hCCDD0000, 32'h00000104, 4'b0011, 32'h0000AABB, 1, 0, 32'h00000080, 4, 0);
        run(0, 3'b001, 32'h00000103, 32'h00000000, 0, 32'h34000000, 32'h00000012, 2, 32'h00000100, 4'b1000, 32'h00000000, 32'h00000104, 4'b0001, 32'h00000000, 1, 0, 32'h00001234, 4, 0);
        run(1, 3'b000, 32'h00000001, 32'h000000A5, 0, JUNK,         JUNK,         1, 32'h00000000, 4'b0010, 32'h0000A500, 32'h0,        4'b0000, 32'h0,        1, 0, 32'h00001234, 3, 0);
        run(0, 3'b010, 32'hFFFFFFFE, 32'h00000000, 0, 32'hBBAA0000, 32'h0000DDCC, 2, 32'hFFFFFFFC, 4'b1100, 32'h00000000, 32'h00000000, 4'b0011, 32'h00000000, 1, 0, 32'hDDCCBBAA, 4, 0);
        run(0, 3'b101, 32'h00000002, 32'h00000000, 0, 32'h9ABC0000, JUNK,         1, 32'h00000000, 4'b1100, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'h00009ABC, 3, 0);
        run(0, 3'b001, 32'h00000002, 32'h00000000, 0, 32'h9ABC0000, JUNK,         1, 32'h00000000, 4'b1100, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'hFFFF9ABC, 3, 0);
        run(1, 3'b001, 32'h00000003, 32'h0000BEEF, 0, JUNK,         JUNK,         2, 32'h00000000, 4'b1000, 32'hEF000000, 32'h00000004, 4'b0001, 32'h000000BE, 1, 0, 32'hFFFF9ABC, 4, 0);
        run(0, 3'b110, 32'h00000100, 32'h00000000, 0, JUNK,         JUNK,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 32'h00000000, 2, 0);
        run(0, 3'b010, 32'h00000200, 32'h00000000, 5, 32'h11223344, JUNK,         1, 32'h00000200, 4'b1111, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'h11223344, 8, 0);
        run(0, 3'b010, 32'h00000040, 32'h00000000, 2, 32'h13579BDF, JUNK,         1, 32'h00000040, 4'b1111, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'h13579BDF, 5, 1);

        // Reset pulsed while the first beat waits for ack.
        @(posedge i_clk);
        #1;
        ack_delay = 50;
        i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h00000200; i_wdata = 32'h0; i_req = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("pre_rst_bus_req", 32'(o_bus_req), 32'd1);
        #2;
        i_resetn = 1'b0;
        #1;
        chk("midrst_bus_req", 32'(o_bus_req), 32'd0);
        chk("midrst_bus_addr", o_bus_addr, 32'h0);
        chk("midrst_bus_be", 32'(o_bus_be), 32'd0);
        chk("midrst_stall", 32'(o_stall), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_err", 32'(o_err), 32'd0);
        chk("midrst_rd_dmem", o_rd_dmem, 32'h0);
        i_req = 1'b0;
        @(negedge i_clk);
        i_resetn = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("post_rst_idle_req", 32'(o_bus_req), 32'd0);
        chk("post_rst_idle_done", 32'(o_done), 32'd0);

        run(0, 3'b010, 32'h00000100, 32'h00000000, 0, 32'hCAFEF00D, JUNK,         1, 32'h00000100, 4'b1111, 32'h00000000, 32'h0,        4'b0000, 32'h0,        1, 0, 32'hCAFEF00D, 3, 0);
`ifdef LSU_TIMEOUT_EN
        run(0, 3'b010, 32'h00000300, 32'h00000000, 1000, JUNK,      JUNK,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1, 32'h00000000, 10, 0);
`endif

        repeat (3) @(negedge i_clk);
        chk("beat_queue_drained", beat_q.size(), 32'd0);
        chk("done_queue_drained", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
